// File: rtl/way_age_tracker.sv
// Per-set, per-way age table for replacement selection. Accessed ways reset to
// age 0, other valid ways age with saturation; a sweep FSM clears the table.
module way_age_tracker #(
  parameter int NUM_WAY                  = 16,
  parameter int NUM_SET                  = 16,
  parameter int SET_PTR_WIDTH_IN_BITS    = $clog2(NUM_SET),
  parameter int WAY_PTR_WIDTH_IN_BITS    = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1,
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic                                         update_valid_in,
  input  logic [1:0]                                   update_type_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             update_set_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             update_way_in,
  input  logic                                         query_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             query_set_in,
  output logic                                         query_ready_out,
  output logic                                         query_valid_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_age_flatted_out,
  output logic [NUM_WAY-1:0]                           way_valid_out,
  input  logic                                         flush_in,
  output logic                                         busy_out
);

  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                                 state_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       sweep_cnt_q;
  logic [NUM_WAY-1:0][W-1:0]              age_q   [NUM_SET];
  logic [NUM_WAY-1:0]                     valid_q [NUM_SET];

  logic [NUM_WAY-1:0][W-1:0]              cur_age;
  logic [NUM_WAY-1:0]                     cur_valid;
  logic [NUM_WAY-1:0][W-1:0]              upd_age;
  logic [NUM_WAY-1:0]                     upd_valid;
  logic                                   query_accept;

  assign query_ready_out = ~busy_out;
  assign query_accept    = query_valid_in & query_ready_out;

  // Next contents of the addressed set; a hit to an invalid way is a fill.
  always_comb begin
    cur_age   = age_q[update_set_in];
    cur_valid = valid_q[update_set_in];
    upd_age   = cur_age;
    upd_valid = cur_valid;
    case (update_type_in)
      2'b00, 2'b01: begin
        for (int unsigned w = 0; w < NUM_WAY; w++) begin
          if (WAY_PTR_WIDTH_IN_BITS'(w) == update_way_in) begin
            upd_age[w]   = '0;
            upd_valid[w] = 1'b1;
          end else if (cur_valid[w] && (cur_age[w] != '1)) begin
            upd_age[w] = cur_age[w] + 1'b1;
          end
        end
      end
      2'b10: begin
        for (int unsigned w = 0; w < NUM_WAY; w++) begin
          if (WAY_PTR_WIDTH_IN_BITS'(w) == update_way_in) begin
            upd_age[w]   = '0;
            upd_valid[w] = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q             <= IDLE;
      sweep_cnt_q         <= '0;
      busy_out            <= 1'b0;
      query_valid_out     <= 1'b0;
      way_age_flatted_out <= '0;
      way_valid_out       <= '0;
      for (int unsigned s = 0; s < NUM_SET; s++) begin
        age_q[s]   <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      // Query reads pre-update state so a same-edge update is not visible.
      query_valid_out <= query_accept;
      if (query_accept) begin
        way_age_flatted_out <= age_q[query_set_in];
        way_valid_out       <= valid_q[query_set_in];
      end

      case (state_q)
        IDLE: begin
          if (flush_in) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
            busy_out    <= 1'b1;
          end else if (update_valid_in) begin
            age_q[update_set_in]   <= upd_age;
            valid_q[update_set_in] <= upd_valid;
          end
        end
        SWEEP: begin
          age_q[sweep_cnt_q]   <= '0;
          valid_q[sweep_cnt_q] <= '0;
          if (sweep_cnt_q == LAST_SET) begin
            state_q  <= IDLE;
            busy_out <= 1'b0;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_way_age_tracker.sv
// Scoreboard bench for way_age_tracker: directed scenarios plus random traffic
// checked against an integer reference model of the age rules.
module tb_way_age_tracker;

  localparam int NW = 16;
  localparam int NS = 16;
  localparam int SW = 4;
  localparam int WW = 4;
  localparam int AW = 4;
  localparam int MAXAGE = 15;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              update_valid_in;
  logic [1:0]        update_type_in;
  logic [SW-1:0]     update_set_in;
  logic [WW-1:0]     update_way_in;
  logic              query_valid_in;
  logic [SW-1:0]     query_set_in;
  logic              query_ready_out;
  logic              query_valid_out;
  logic [AW*NW-1:0]  way_age_flatted_out;
  logic [NW-1:0]     way_valid_out;
  logic              flush_in;
  logic              busy_out;

  way_age_tracker #(
    .NUM_WAY(NW),
    .NUM_SET(NS),
    .SINGLE_WAY_WIDTH_IN_BITS(AW)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .update_valid_in(update_valid_in),
    .update_type_in(update_type_in),
    .update_set_in(update_set_in),
    .update_way_in(update_way_in),
    .query_valid_in(query_valid_in),
    .query_set_in(query_set_in),
    .query_ready_out(query_ready_out),
    .query_valid_out(query_valid_out),
    .way_age_flatted_out(way_age_flatted_out),
    .way_valid_out(way_valid_out),
    .flush_in(flush_in),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NW-1:0]    valid;
    logic [AW*NW-1:0] ages;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  int   m_age   [NS][NW];
  bit   m_valid [NS][NW];
  int   m_busy = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_age[s][w]   = 0;
        m_valid[s][w] = 0;
      end
  endfunction

  function automatic exp_t snapshot(input int s);
    exp_t e;
    for (int w = 0; w < NW; w++) begin
      e.valid[w]        = m_valid[s][w];
      e.ages[w*AW +: AW] = AW'(m_age[s][w]);
    end
    return e;
  endfunction

  function automatic void model_update(input int t, input int s, input int w);
    if (t == 0 || t == 1) begin
      for (int v = 0; v < NW; v++)
        if (v != w && m_valid[s][v])
          m_age[s][v] = (m_age[s][v] + 1 > MAXAGE) ? MAXAGE : m_age[s][v] + 1;
      m_age[s][w]   = 0;
      m_valid[s][w] = 1;
    end else if (t == 2) begin
      m_age[s][w]   = 0;
      m_valid[s][w] = 0;
    end
  endfunction

  // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input bit uv, input int ut, input int us, input int uw,
                      input bit qv, input int qs, input bit fl);
    bit acc_q;
    update_valid_in = uv;
    update_type_in  = 2'(ut);
    update_set_in   = SW'(us);
    update_way_in   = WW'(uw);
    query_valid_in  = qv;
    query_set_in    = SW'(qs);
    flush_in        = fl;
    #1;
    check("busy_out", busy_out, m_busy > 0);
    check("query_ready_out", query_ready_out, m_busy == 0);
    acc_q = qv && (m_busy == 0);
    if (acc_q) sb.push_back(snapshot(qs));
    if (m_busy > 0) m_busy--;
    else if (fl) begin
      m_busy = NS;
      model_clear();
    end else if (uv) model_update(ut, us, uw);
    @(posedge clk_in);
    #1;
    check("query_valid_out", query_valid_out, acc_q);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic query(input int s);
    step(0, 0, 0, 0, 1, s, 0);
  endtask

  always @(negedge clk_in) begin
    if (reset_in && query_valid_out) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got query_valid_out=1 expected no pending query");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("way_valid_out", way_valid_out, e.valid);
        check("way_age_flatted_out", way_age_flatted_out, e.ages);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in = 1'b0;
    update_valid_in = 0; update_type_in = 0; update_set_in = 0; update_way_in = 0;
    query_valid_in = 0; query_set_in = 0; flush_in = 0;
    model_clear();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_busy", busy_out, 1'b0);
    check("reset_ready", query_ready_out, 1'b1);
    check("reset_qvalid", query_valid_out, 1'b0);
    check("reset_valid_mask", way_valid_out, '0);
    check("reset_ages", way_age_flatted_out, '0);
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Empty set after reset.
    query(3);
    // Consecutive fills then query: ages 2,1,0.
    step(1, 1, 2, 0, 0, 0, 0);
    step(1, 1, 2, 1, 0, 0, 0);
    step(1, 1, 2, 2, 0, 0, 0);
    query(2);
    // Saturation of a valid way under repeated accesses elsewhere.
    step(1, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 5, 1, 0, 0, 0);
    query(5);
    // Same-cycle hit and query returns pre-update values.
    step(1, 0, 2, 0, 1, 2, 0);
    query(2);
    // Invalidate and reserved type.
    step(1, 2, 2, 1, 0, 0, 0);
    step(1, 3, 2, 2, 0, 0, 0);
    query(2);

    // Populate all sets, flush, drop a mid-sweep update, then verify empty.
    for (int s = 0; s < NS; s++) step(1, 1, s, s % NW, 0, 0, 0);
    step(1, 1, 7, 3, 1, 7, 1);
    for (int i = 0; i < NS; i++) begin
      if (i == 10) step(1, 1, 0, 4, 1, 0, 0);
      else step(0, 0, 0, 0, 0, 0, 0);
    end
    for (int s = 0; s < NS; s++) query(s);

    // Reset in the middle of a sweep.
    for (int s = 0; s < NS; s++) step(1, 0, s, (s * 3) % NW, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(5);
    update_valid_in = 0; query_valid_in = 0; flush_in = 0;
    #2;
    reset_in = 1'b0;
    #1;
    check("abort_busy", busy_out, 1'b0);
    check("abort_qvalid", query_valid_out, 1'b0);
    check("abort_ready", query_ready_out, 1'b1);
    check("abort_valid_mask", way_valid_out, '0);
    model_clear();
    m_busy = 0;
    sb.delete();
    @(negedge clk_in);
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;
    for (int s = 0; s < NS; s++) query(s);

    // Random traffic concentrated on a few sets so saturation occurs.
    for (int i = 0; i < 3000; i++) begin
      bit uv, qv, fl;
      uv = ($urandom_range(0, 3) != 0);
      qv = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 199) == 0);
      step(uv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
           qv, $urandom_range(0, 3), fl);
    end
    idle(NS + 3);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
